// File: rtl/fetch_ins_queue_if.sv
// Fetch/decode handshake bundle for the fetch instruction queue.
// master = fetch + decode environment, slave = the queue itself.
interface fetch_ins_queue_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                  iRstingBlk;
  logic [DATA_WIDTH-1:0] iCurrentPC;
  logic [DATA_WIDTH-1:0] iPcAdd4;
  logic [DATA_WIDTH-1:0] iIns;
  logic                  iFeBjEn;
  logic                  oFeStl;
  logic                  iDeRdy;
  logic                  oDeVld;
  logic [DATA_WIDTH-1:0] oDeIns;
  logic [DATA_WIDTH-1:0] oDePc;
  logic [DATA_WIDTH-1:0] oDePcAdd4;
  logic [CNT_W-1:0]      oCount;

  modport master (
    output iRstingBlk, iCurrentPC, iPcAdd4, iIns, iFeBjEn, iDeRdy,
    input  oFeStl, oDeVld, oDeIns, oDePc, oDePcAdd4, oCount
  );

  modport slave (
    input  iRstingBlk, iCurrentPC, iPcAdd4, iIns, iFeBjEn, iDeRdy,
    output oFeStl, oDeVld, oDeIns, oDePc, oDePcAdd4, oCount
  );
endinterface

// File: rtl/fetch_ins_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {ins, pc, pc+4} with
// valid/ready to decode, flush on branch/jump redirect and stall back to PC generation.
module fetch_ins_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input logic             clk,
  input logic             rstn,
  fetch_ins_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] insMem   [DEPTH];
  logic [DATA_WIDTH-1:0] pcMem    [DEPTH];
  logic [DATA_WIDTH-1:0] pcAdd4Mem[DEPTH];

  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] count;
  logic             full, empty, stall, push, pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign stall = full & ~bus.iDeRdy;
  assign pop   = ~empty & bus.iDeRdy & ~bus.iFeBjEn;
  // A stalled fetch is dropped here; PC generation re-presents it next cycle.
  assign push  = bus.iRstingBlk & ~bus.iFeBjEn & ~stall;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (bus.iFeBjEn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage is not reset; validity is tracked solely by count.
  always_ff @(posedge clk) begin
    if (rstn && push) begin
      insMem[wrPtr]    <= bus.iIns;
      pcMem[wrPtr]     <= bus.iCurrentPC;
      pcAdd4Mem[wrPtr] <= bus.iPcAdd4;
    end
  end

  always_comb begin
    bus.oFeStl    = stall;
    bus.oDeVld    = ~empty;
    bus.oCount    = count;
    bus.oDeIns    = '0;
    bus.oDePc     = '0;
    bus.oDePcAdd4 = '0;
    if (!empty) begin
      bus.oDeIns    = insMem[rdPtr];
      bus.oDePc     = pcMem[rdPtr];
      bus.oDePcAdd4 = pcAdd4Mem[rdPtr];
    end
  end

  countBound: assert property (@(posedge clk) disable iff (!rstn) count <= CNT_W'(DEPTH));
  noOverflow: assert property (@(posedge clk) disable iff (!rstn) !(push && full && !pop));
  vldMatch:   assert property (@(posedge clk) disable iff (!rstn) bus.oDeVld == (count != '0));
endmodule
